uart_rx_axis: RTL
=================

// Module: uart_rx_axis
// PURPOSE
//   Standalone UART receiver: deserialises the uart_rx pin and presents each good byte as an AXI-stream beat.
//   A DEPTH-entry FIFO decouples the line from downstream back-pressure; bytes are never overwritten.
//   Detects framing errors, parity errors and overruns.
//   Sits between the physical RX pin and the stream mux; drop-in source for the mux's UART RX input.
// PARAMETERS
//   CLK_BITS    8  width of clk_per_bit
//   DATA_WIDTH  8  data bits per frame, LSB first
//   PARITY_EN   0  1 = one parity bit follows the data
//   PARITY_ODD  0  1 = odd parity, 0 = even (used only when PARITY_EN=1)
//   STOP_BITS   1  stop bits checked per frame (1 or 2)
//   DEPTH       4  output FIFO entries, power of two, >=2
// PORTS
//   clk          in   1           system clock
//   rst          in   1           synchronous, active-high reset
//   clk_per_bit  in   CLK_BITS    clocks per bit; values <4 unsupported; latched when a start edge is detected
//   uart_rx      in   1           serial RX pin, asynchronous, idle high
//   uart_out     axi_stream_if.master  tdata[DATA_WIDTH], tvalid, tready
//   frame_err    out  1           1-cycle pulse: a sampled stop bit was 0
//   parity_err   out  1           1-cycle pulse: parity mismatch
//   overrun      out  1           1-cycle pulse: good byte dropped, FIFO full
//   rx_busy      out  1           high while the FSM is not in IDLE
// BEHAVIOUR
//   Reset: sync flops=1, FSM=IDLE, FIFO empty, tvalid=0, tdata=0, all pulses=0, rx_busy=0. Reset mid-frame abandons the frame.
//   Input: 2-flop synchroniser; the FSM uses only the synchronised value rx_s.
//   Bit timer: a down-counter. On reaching 0 it reloads with cpb-1 and raises a sample strobe.
//   cpb is the value of clk_per_bit latched at the start edge.
//   IDLE: when rx_s==0, latch cpb, load the timer with cpb>>1 and go to START.
//   START: at the strobe (mid start bit), if rx_s==0 go to DATA; otherwise it is a glitch: go to IDLE with no pulse.
//   DATA: at each strobe, shift rx_s into bit[k], k=0..DATA_WIDTH-1.
//     After the last bit go to PARITY if PARITY_EN, else to STOP.
//   PARITY: at the strobe, compare rx_s with ^data ^ PARITY_ODD and record a mismatch; go to STOP.
//   STOP: sample STOP_BITS strobes and record any 0 sample. After the last stop sample, in that same cycle:
//     - if any stop sample was 0: pulse frame_err; drop the byte.
//     - else if parity mismatched: pulse parity_err; drop the byte.
//     - else push the byte to the FIFO, or pulse overrun if the FIFO is full.
//     - the FSM returns to IDLE at mid stop bit, so back-to-back frames are received.
//     - frame_err takes priority; only one of the three pulses fires per frame.
//   Sample timing: with the synchronised falling edge at cycle 0, bit j (start=0) is sampled at cycle (cpb>>1) + j*cpb.
//   FIFO and stream:
//     - tvalid = !empty; tdata = the head entry.
//     - A pop occurs when tvalid && tready.
//     - A push lands at the tail and is visible on tvalid in the next cycle when the FIFO was empty.
//     - Simultaneous push and pop while full is legal: the pop frees a slot, the push is accepted, no overrun.
//     - tdata is held stable while tvalid && !tready. Order is strictly FIFO.
//     - Pointers carry one extra wrap bit: full = MSBs differ and the rest are equal.
//   Widths: bit counter $clog2(DATA_WIDTH+1); stop counter 2 bits; timer CLK_BITS bits; no overflow is possible.
// STRUCTURE
//   uart_pkg holds:
//     - typedef enum logic[2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP} uart_rx_state_t
//     - localparam PARITY_EVEN=0, PARITY_ODD=1
//   Sub-module uart_rx_fifo #(WIDTH, DEPTH):
//     - inputs push, din, pop; outputs dout, empty, full.
//     - synchronous, active-high rst; FIFO state only, no sync/FSM logic.
//   The top level contains the synchroniser, bit timer, FSM, error flags and stream glue.
// TESTING
//   All scenarios use clk_per_bit=16, 8N1 unless stated.
//   1. Send 0xA5 with tready=1 -> exactly one beat tdata=0xA5 within 1 cycle after the stop sample; no pulses.
//   2. Send 0x00, 0xFF, 0x81 back-to-back with no idle gap -> three beats in order; rx_busy low only briefly between frames.
//   3. Pull uart_rx low for 5 cycles, then release -> no beat, no pulse; FSM back in IDLE before the next strobe.
//   4. Send 0x3C with the stop bit driven 0 -> frame_err pulses once; no beat; the next clean 0x3C is received.
//   5. With tready=0, send 0x01..0x05 (DEPTH=4) -> overrun pulses on 0x05.
//      Then with tready=1 -> beats 0x01, 0x02, 0x03, 0x04 only.
//      Also: tready pulsed in the same cycle as a push while full -> no overrun.
//   6. PARITY_EN=1 even: 0x07 with parity 0 -> parity_err, no beat; 0x07 with parity 1 -> beat 0x07.
//      Assert rst during DATA of the next frame -> tvalid=0 next cycle; a following 0x5A is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types for the UART receiver: FSM state encoding and parity selectors.
package uart_pkg;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } uart_rx_state_t;

    localparam int unsigned PARITY_EVEN = 0;
    localparam int unsigned PARITY_ODD  = 1;

endpackage

// File: rtl/axi_stream_if.sv
// AXI-stream beat bundle.
//   tdata  : payload
//   tvalid : source has a beat
//   tready : sink accepts the beat
interface axi_stream_if #(
    parameter int unsigned DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] tdata;
    logic                  tvalid;
    logic                  tready;

    modport master (output tdata, output tvalid, input  tready);
    modport slave  (input  tdata, input  tvalid, output tready);
endinterface

// File: rtl/uart_rx_fifo.sv
// Small synchronous FIFO with a wrap bit on each pointer.
//   push/din : write at tail (accepted when not full, or full with a pop)
//   pop      : advance head when not empty
//   dout     : head entry; empty/full status
module uart_rx_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             w_do_push;
    logic             w_do_pop;

    assign empty = (r_wr_ptr == r_rd_ptr);
    assign full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign dout  = r_mem[r_rd_ptr[AW-1:0]];

    // A pop while full frees the slot the push writes into.
    assign w_do_push = push && (!full || pop);
    assign w_do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr[AW-1:0]] <= din;
                r_wr_ptr                <= r_wr_ptr + (AW+1)'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/uart_rx_axis.sv
// UART receiver presenting good bytes as AXI-stream beats through a FIFO.
//   clk, rst     : clock, synchronous active-high reset
//   clk_per_bit  : clocks per bit, latched at the start edge
//   uart_rx      : asynchronous serial input, idle high
//   uart_out     : stream master (tdata/tvalid/tready)
//   frame_err    : pulse, a stop sample was 0
//   parity_err   : pulse, parity mismatch
//   overrun      : pulse, good byte dropped on a full FIFO
//   rx_busy      : FSM not idle
module uart_rx_axis #(
    parameter int unsigned CLK_BITS   = 8,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned PARITY_EN  = 0,
    parameter int unsigned PARITY_ODD = 0,
    parameter int unsigned STOP_BITS  = 1,
    parameter int unsigned DEPTH      = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CLK_BITS-1:0] clk_per_bit,
    input  logic                uart_rx,
    axi_stream_if.master        uart_out,
    output logic                frame_err,
    output logic                parity_err,
    output logic                overrun,
    output logic                rx_busy
);
    import uart_pkg::uart_rx_state_t;
    import uart_pkg::RX_IDLE;
    import uart_pkg::RX_START;
    import uart_pkg::RX_DATA;
    import uart_pkg::RX_PARITY;
    import uart_pkg::RX_STOP;

    localparam int unsigned           BCNT_W      = $clog2(DATA_WIDTH + 1);
    localparam logic [BCNT_W-1:0]     LAST_BIT    = BCNT_W'(DATA_WIDTH - 1);
    localparam logic [1:0]            LAST_STOP   = 2'(STOP_BITS - 1);
    localparam logic                  PAR_ODD_BIT = 1'(PARITY_ODD);

    uart_rx_state_t        r_state, w_state_nxt;
    logic [1:0]            r_sync;
    logic [CLK_BITS-1:0]   r_timer, w_timer_nxt;
    logic [CLK_BITS-1:0]   r_cpb, w_cpb_nxt;
    logic [DATA_WIDTH-1:0] r_data, w_data_nxt;
    logic [BCNT_W-1:0]     r_bitcnt, w_bitcnt_nxt;
    logic [1:0]            r_stopcnt, w_stopcnt_nxt;
    logic                  r_par_bad, w_par_bad_nxt;
    logic                  r_stop_bad, w_stop_bad_nxt;
    logic                  r_frame_err, w_frame_err_nxt;
    logic                  r_parity_err, w_parity_err_nxt;
    logic                  r_overrun, w_overrun_nxt;
    logic                  r_rx_busy;
    logic                  w_rx_s, w_strobe, w_good, w_push, w_pop;
    logic                  w_empty, w_full;
    logic [DATA_WIDTH-1:0] w_dout;

    // Two-flop synchroniser on the raw pin.
    always_ff @(posedge clk) begin
        if (rst) r_sync <= 2'b11;
        else     r_sync <= {r_sync[0], uart_rx};
    end

    assign w_rx_s   = r_sync[1];
    assign w_strobe = (r_state != RX_IDLE) && (r_timer == '0);
    assign w_pop    = !w_empty && uart_out.tready;

    // Next-state, datapath and end-of-frame decisions.
    always_comb begin
        w_state_nxt      = r_state;
        w_timer_nxt      = w_strobe ? (r_cpb - CLK_BITS'(1)) : (r_timer - CLK_BITS'(1));
        w_cpb_nxt        = r_cpb;
        w_data_nxt       = r_data;
        w_bitcnt_nxt     = r_bitcnt;
        w_stopcnt_nxt    = r_stopcnt;
        w_par_bad_nxt    = r_par_bad;
        w_stop_bad_nxt   = r_stop_bad;
        w_frame_err_nxt  = 1'b0;
        w_parity_err_nxt = 1'b0;
        w_good           = 1'b0;

        case (r_state)
            RX_IDLE: begin
                w_timer_nxt = r_timer;
                if (!w_rx_s) begin
                    w_state_nxt    = RX_START;
                    w_cpb_nxt      = clk_per_bit;
                    w_timer_nxt    = clk_per_bit >> 1;
                    w_bitcnt_nxt   = '0;
                    w_stopcnt_nxt  = '0;
                    w_par_bad_nxt  = 1'b0;
                    w_stop_bad_nxt = 1'b0;
                end
            end
            RX_START: begin
                if (w_strobe) w_state_nxt = w_rx_s ? RX_IDLE : RX_DATA;
            end
            RX_DATA: begin
                if (w_strobe) begin
                    w_data_nxt = {w_rx_s, r_data[DATA_WIDTH-1:1]};
                    if (r_bitcnt == LAST_BIT) begin
                        w_bitcnt_nxt = '0;
                        w_state_nxt  = (PARITY_EN != 0) ? RX_PARITY : RX_STOP;
                    end else begin
                        w_bitcnt_nxt = r_bitcnt + BCNT_W'(1);
                    end
                end
            end
            RX_PARITY: begin
                if (w_strobe) begin
                    w_par_bad_nxt = (w_rx_s != (^r_data ^ PAR_ODD_BIT));
                    w_state_nxt   = RX_STOP;
                end
            end
            RX_STOP: begin
                if (w_strobe) begin
                    if (r_stopcnt == LAST_STOP) begin
                        // Leave at mid stop bit so the next start edge is caught.
                        w_state_nxt = RX_IDLE;
                        if (r_stop_bad || !w_rx_s) w_frame_err_nxt  = 1'b1;
                        else if (r_par_bad)        w_parity_err_nxt = 1'b1;
                        else                       w_good           = 1'b1;
                    end else begin
                        w_stopcnt_nxt  = r_stopcnt + 2'd1;
                        w_stop_bad_nxt = r_stop_bad | !w_rx_s;
                    end
                end
            end
            default: w_state_nxt = RX_IDLE;
        endcase

        w_push        = w_good && (!w_full || w_pop);
        w_overrun_nxt = w_good && w_full && !w_pop;
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= RX_IDLE;
            r_timer      <= '0;
            r_cpb        <= '0;
            r_data       <= '0;
            r_bitcnt     <= '0;
            r_stopcnt    <= '0;
            r_par_bad    <= 1'b0;
            r_stop_bad   <= 1'b0;
            r_frame_err  <= 1'b0;
            r_parity_err <= 1'b0;
            r_overrun    <= 1'b0;
            r_rx_busy    <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_timer      <= w_timer_nxt;
            r_cpb        <= w_cpb_nxt;
            r_data       <= w_data_nxt;
            r_bitcnt     <= w_bitcnt_nxt;
            r_stopcnt    <= w_stopcnt_nxt;
            r_par_bad    <= w_par_bad_nxt;
            r_stop_bad   <= w_stop_bad_nxt;
            r_frame_err  <= w_frame_err_nxt;
            r_parity_err <= w_parity_err_nxt;
            r_overrun    <= w_overrun_nxt;
            r_rx_busy    <= (w_state_nxt != RX_IDLE);
        end
    end

    uart_rx_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_push),
        .din   (w_data_nxt),
        .pop   (w_pop),
        .dout  (w_dout),
        .empty (w_empty),
        .full  (w_full)
    );

    assign uart_out.tdata  = w_dout;
    assign uart_out.tvalid = !w_empty;
    assign frame_err       = r_frame_err;
    assign parity_err      = r_parity_err;
    assign overrun         = r_overrun;
    assign rx_busy         = r_rx_busy;

endmodule
